// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel datapath: two line buffers plus a 3x3 shift window.
// Optional SOBEL_WIN_COORD_EN adds centre-coordinate outputs registered alongside each window.
module sobel_window_gen #(
    parameter int MAX_WIDTH  = 64,
    parameter int MAX_HEIGHT = 64
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]    line_width_i,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]   frame_height_i,
    input  logic                              pix_valid_i,
    output logic                              pix_ready_o,
    input  logic signed [7:0]                 pix_i,
    input  logic                              pix_sof_i,
    output logic                              win_valid_o,
    input  logic                              win_ready_i,
    output logic signed [7:0]                 p00_o,
    output logic signed [7:0]                 p01_o,
    output logic signed [7:0]                 p02_o,
    output logic signed [7:0]                 p10_o,
    output logic signed [7:0]                 p11_o,
    output logic signed [7:0]                 p12_o,
    output logic signed [7:0]                 p20_o,
    output logic signed [7:0]                 p21_o,
    output logic signed [7:0]                 p22_o,
`ifdef SOBEL_WIN_COORD_EN
    output logic [$clog2(MAX_WIDTH)-1:0]      win_col_o,
    output logic [$clog2(MAX_HEIGHT)-1:0]     win_row_o,
`endif
    output logic                              win_last_o
);

    localparam int WW = $clog2(MAX_WIDTH + 1);
    localparam int HW = $clog2(MAX_HEIGHT + 1);
    localparam int CW = $clog2(MAX_WIDTH);
    localparam int RW = $clog2(MAX_HEIGHT);

    function automatic logic [WW-1:0] clamp_w(input logic [WW-1:0] v);
        if (v < WW'(3))              return WW'(3);
        else if (v > WW'(MAX_WIDTH)) return WW'(MAX_WIDTH);
        else                         return v;
    endfunction

    function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] v);
        if (v < HW'(3))               return HW'(3);
        else if (v > HW'(MAX_HEIGHT)) return HW'(MAX_HEIGHT);
        else                          return v;
    endfunction

    logic [WW-1:0]     width_q;
    logic [HW-1:0]     height_q;
    logic              started_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic signed [7:0] lb0 [MAX_WIDTH];
    logic signed [7:0] lb1 [MAX_WIDTH];

    logic              accept;
    logic              restart;
    logic [WW-1:0]     w_eff;
    logic [HW-1:0]     h_eff;
    logic [CW-1:0]     cur_col;
    logic [RW-1:0]     cur_row;
    logic              col_end;
    logic              row_end;
    logic              produce;
    logic signed [7:0] top;
    logic signed [7:0] mid;

    // A pixel without any SOF since reset starts a frame exactly like an SOF pixel.
    always_comb begin
        pix_ready_o = !rst_i && (!win_valid_o || win_ready_i);
        accept      = pix_valid_i && pix_ready_o;
        restart     = pix_sof_i || !started_q;
        w_eff       = restart ? clamp_w(line_width_i)   : width_q;
        h_eff       = restart ? clamp_h(frame_height_i) : height_q;
        cur_col     = restart ? '0 : col_q;
        cur_row     = restart ? '0 : row_q;
        col_end     = (WW'(cur_col) == w_eff - WW'(1));
        row_end     = (HW'(cur_row) == h_eff - HW'(1));
        produce     = (cur_col >= CW'(2)) && (cur_row >= RW'(2));
        top         = lb0[cur_col];
        mid         = lb1[cur_col];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            width_q     <= WW'(3);
            height_q    <= HW'(3);
            started_q   <= 1'b0;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_o <= 1'b0;
            win_last_o  <= 1'b0;
            {p00_o, p01_o, p02_o, p10_o, p11_o, p12_o, p20_o, p21_o, p22_o} <= '0;
`ifdef SOBEL_WIN_COORD_EN
            win_col_o   <= '0;
            win_row_o   <= '0;
`endif
        end else if (accept) begin
            started_q <= 1'b1;
            if (restart) begin
                width_q  <= w_eff;
                height_q <= h_eff;
            end
            if (col_end) begin
                col_q <= '0;
                row_q <= row_end ? '0 : cur_row + RW'(1);
            end else begin
                col_q <= cur_col + CW'(1);
                row_q <= cur_row;
            end
            // Every accepted pixel shifts the window so columns 0/1 are already in place at col >= 2.
            p00_o <= p01_o;  p01_o <= p02_o;  p02_o <= top;
            p10_o <= p11_o;  p11_o <= p12_o;  p12_o <= mid;
            p20_o <= p21_o;  p21_o <= p22_o;  p22_o <= pix_i;
            win_valid_o <= produce;
            win_last_o  <= produce && col_end && row_end;
`ifdef SOBEL_WIN_COORD_EN
            if (produce) begin
                win_col_o <= cur_col - CW'(1);
                win_row_o <= cur_row - RW'(1);
            end
`endif
        end else if (win_ready_i) begin
            win_valid_o <= 1'b0;
            win_last_o  <= 1'b0;
        end
    end

    // NOTE: line buffers carry no reset; stale rows are never read into a valid window.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            lb0[cur_col] <= mid;
            lb1[cur_col] <= pix_i;
        end
    end

endmodule
